// File: rtl/ddr_port_arbiter_pkg.sv
// Shared definitions for the DDR command-port arbiter: address width,
// FSM state encoding (one-hot), starvation default and the round-robin pick.
package ddr_port_arbiter_pkg;

    localparam int CTRL_ADDR_WIDTH = 28;
    localparam int ARB_STARVE_MAX  = 4;

    typedef enum logic [3:0] {
        ARB_IDLE    = 4'b0001,
        ARB_CMD     = 4'b0010,
        ARB_RD_DATA = 4'b0100,
        ARB_WR_DATA = 4'b1000
    } arb_state_e;

    // Round-robin pick: 1 when the write side wins. A lone requester always
    // wins; on contention the side that did not win last time goes first.
    function automatic logic rr_pick_wr(input logic rd_req, input logic wr_req,
                                        input logic last_wr);
        if (rd_req && wr_req) begin
            return !last_wr;
        end
        return wr_req;
    endfunction

endpackage

// File: rtl/ddr_port_arbiter_burst_beat_cnt.sv
// Data-beat counter for one burst. Cleared when the command is accepted,
// counts beats while enabled, flags the final beat and pulses done one
// cycle after that beat. One extra bit keeps len = 15 from wrapping early.
module burst_beat_cnt #(
    parameter int LEN_W = 4
) (
    input  logic             ddr_clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic             en_i,
    input  logic             beat_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             last_o,
    output logic             done_o
);

    logic [LEN_W:0] cnt_q, cnt_d;
    logic           done_q, done_d;

    // The current beat is the final one once len beats have already passed.
    assign last_o = (cnt_q == {1'b0, len_i});
    assign done_o = done_q;

    // Next count: clear on a new command, otherwise advance on each beat.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i && beat_i) begin
            cnt_d  = cnt_q + (LEN_W + 1)'(1);
            done_d = last_o;
        end
    end

    // Counter and done-pulse registers.
    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Burst-level arbiter sharing the DDR command port between the display read
// path and the camera write path. Round-robin by default; defining
// ARB_RD_URGENT_EN lets an urgent display read win contention, bounded by a
// starvation counter that forces a pending write through after STARVE_MAX
// consecutive urgent read wins.
module ddr_port_arbiter
    import ddr_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = CTRL_ADDR_WIDTH,
    parameter int LEN_W      = 4,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              ddr_clk,
    input  logic              rstn,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_adr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    input  logic              rd_urgent_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_adr_i,
    input  logic [LEN_W-1:0]  wr_len_i,
    output logic              rd_gnt_o,
    output logic              wr_gnt_o,
    output logic              rd_done_o,
    output logic              wr_done_o,
    output logic              ddr_cmd_valid_o,
    input  logic              ddr_cmd_ready_i,
    output logic              ddr_cmd_wr_o,
    output logic [ADDR_W-1:0] ddr_cmd_adr_o,
    output logic [LEN_W-1:0]  ddr_cmd_len_o,
    input  logic              ddr_rbeat_i,
    input  logic              ddr_wbeat_i,
    output logic              busy_o,
    output logic              owner_o
);

    arb_state_e        state_q;
    logic              cmd_valid_q;
    logic              cmd_wr_q;
    logic [ADDR_W-1:0] cmd_adr_q;
    logic [LEN_W-1:0]  cmd_len_q;
    logic              rd_gnt_q, wr_gnt_q;
    logic              busy_q, owner_q, last_wr_q;

    logic pick_wr;
    logic in_data, beat_sel, cnt_start, cnt_last, cnt_done, burst_fin;

    assign in_data   = (state_q == ARB_RD_DATA) || (state_q == ARB_WR_DATA);
    assign beat_sel  = cmd_wr_q ? ddr_wbeat_i : ddr_rbeat_i;
    assign cnt_start = (state_q == ARB_CMD) && ddr_cmd_ready_i;
    assign burst_fin = in_data && beat_sel && cnt_last;

`ifdef ARB_RD_URGENT_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_q;
    logic       contended;

    assign contended = rd_req_i && wr_req_i;

    // Urgent reads win contention until the starvation limit forces a write.
    always_comb begin
        pick_wr = rr_pick_wr(rd_req_i, wr_req_i, last_wr_q);
        if (contended) begin
            if (starve_q >= STARVE_LIM) begin
                pick_wr = 1'b1;
            end else if (rd_urgent_i) begin
                pick_wr = 1'b0;
            end
        end
    end

    // Count consecutive urgent read wins over a waiting write; any write grant clears.
    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= '0;
        end else if ((state_q == ARB_IDLE) && (rd_req_i || wr_req_i)) begin
            if (pick_wr) begin
                starve_q <= '0;
            end else if (contended && rd_urgent_i) begin
                starve_q <= starve_q + 8'd1;
            end
        end
    end
`else
    // Pure round-robin: the urgency hint and starvation limit have no effect.
    logic        unused_urgent;
    logic [31:0] unused_starve_max;

    assign unused_urgent     = rd_urgent_i;
    assign unused_starve_max = 32'(STARVE_MAX);
    assign pick_wr           = rr_pick_wr(rd_req_i, wr_req_i, last_wr_q);
`endif

    burst_beat_cnt #(
        .LEN_W(LEN_W)
    ) u_beat_cnt (
        .ddr_clk (ddr_clk),
        .rstn    (rstn),
        .start_i (cnt_start),
        .en_i    (in_data),
        .beat_i  (beat_sel),
        .len_i   (cmd_len_q),
        .last_o  (cnt_last),
        .done_o  (cnt_done)
    );

    // Arbitration FSM: pick a winner, hold the command until accepted, then wait for the last beat.
    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ARB_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_adr_q   <= '0;
            cmd_len_q   <= '0;
            rd_gnt_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b1;
            last_wr_q   <= 1'b1;
        end else begin
            rd_gnt_q <= 1'b0;
            wr_gnt_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (rd_req_i || wr_req_i) begin
                        state_q     <= ARB_CMD;
                        cmd_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cmd_wr_q    <= pick_wr;
                        owner_q     <= pick_wr;
                        cmd_adr_q   <= pick_wr ? wr_adr_i : rd_adr_i;
                        cmd_len_q   <= pick_wr ? wr_len_i : rd_len_i;
                        rd_gnt_q    <= !pick_wr;
                        wr_gnt_q    <= pick_wr;
                    end
                end
                ARB_CMD: begin
                    if (ddr_cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= cmd_wr_q ? ARB_WR_DATA : ARB_RD_DATA;
                    end
                end
                ARB_RD_DATA, ARB_WR_DATA: begin
                    if (burst_fin) begin
                        state_q   <= ARB_IDLE;
                        busy_q    <= 1'b0;
                        last_wr_q <= cmd_wr_q;
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    cmd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign rd_gnt_o        = rd_gnt_q;
    assign wr_gnt_o        = wr_gnt_q;
    assign rd_done_o       = cnt_done && !cmd_wr_q;
    assign wr_done_o       = cnt_done && cmd_wr_q;
    assign ddr_cmd_valid_o = cmd_valid_q;
    assign ddr_cmd_wr_o    = cmd_wr_q;
    assign ddr_cmd_adr_o   = cmd_adr_q;
    assign ddr_cmd_len_o   = cmd_len_q;
    assign busy_o          = busy_q;
    assign owner_o         = owner_q;

endmodule
